// File: rtl/nios_start_ctrl_if.sv
// Avalon-MM slave bus bundle for the start-button controller.
interface nios_start_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios_start_ctrl.sv
// Start push-button controller: synchroniser, debounce FSM, edge capture and maskable IRQ.
// Optional long-press capture on EDGECAPTURE bit1 enabled by NIOS_START_CTRL_HOLD_EN.
module nios_start_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19,
  parameter int unsigned HOLD_CYCLES     = 100000000,
  parameter int unsigned HOLD_W          = 27
) (
  input  logic              clk,
  input  logic              reset_n,
  nios_start_ctrl_if.slave  bus,
  input  logic              in_port,
  output logic              irq
);

  typedef enum logic [1:0] {StIdleLow, StWaitHigh, StIdleHigh, StWaitLow} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level;
  logic             press;
  logic             long_press;
  logic [1:0]       impl_mask;
  logic [1:0]       mask_q, mask_d;
  logic [1:0]       edge_q, edge_d;
  logic [31:0]      rdata_d;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign unused_wdata = ^bus.writedata[31:2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
    end
  end

  // Debounce FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdleLow;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debounce FSM: next state and window counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdleLow: begin
        if (s2_q) begin
          state_d = StWaitHigh;
          cnt_d   = '0;
        end
      end
      StWaitHigh: begin
        if (!s2_q) begin
          state_d = StIdleLow;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StIdleHigh;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StIdleHigh: begin
        if (!s2_q) begin
          state_d = StWaitLow;
          cnt_d   = '0;
        end
      end
      StWaitLow: begin
        if (s2_q) begin
          state_d = StIdleHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StIdleLow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdleLow;
        cnt_d   = '0;
      end
    endcase
  end

  // Debounce FSM: outputs; press fires on the edge the level rises
  always_comb begin
    level = (state_q == StIdleHigh) || (state_q == StWaitLow);
    press = (state_q == StWaitHigh) && s2_q && (cnt_q == CntLast);
  end

`ifdef NIOS_START_CTRL_HOLD_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              hold_fired_q, hold_fired_d;

  assign impl_mask = 2'b11;

  // Long press fires once per stay in IdleHigh, then the counter parks
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    hold_fired_d = hold_fired_q;
    long_press   = 1'b0;
    if (state_q == StIdleHigh) begin
      if (!hold_fired_q) begin
        if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          long_press   = 1'b1;
          hold_fired_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
    end else begin
      hold_cnt_d   = '0;
      hold_fired_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_q   <= '0;
      hold_fired_q <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      hold_fired_q <= hold_fired_d;
    end
  end
`else
  localparam int unsigned UnusedHold = HOLD_CYCLES + HOLD_W;

  assign impl_mask  = 2'b01;
  assign long_press = 1'b0;
`endif

  // Capture set has priority over a same-edge clear
  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr_en && (bus.address == 2'd2)) begin
      mask_d = bus.writedata[1:0] & impl_mask;
    end
    if (wr_en && (bus.address == 2'd3)) begin
      edge_d = edge_q & ~(bus.writedata[1:0] & impl_mask);
    end
    edge_d[0] = edge_d[0] | press;
    edge_d[1] = edge_d[1] | long_press;
  end

  always_comb begin
    rdata_d = '0;
    unique case (bus.address)
      2'd0:    rdata_d[1:0] = {s2_q, level};
      2'd1:    rdata_d      = '0;
      2'd2:    rdata_d[1:0] = mask_q;
      2'd3:    rdata_d[1:0] = edge_q;
      default: rdata_d      = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q       <= '0;
      edge_q       <= '0;
      bus.readdata <= '0;
    end else begin
      mask_q       <= mask_d;
      edge_q       <= edge_d;
      bus.readdata <= rdata_d;
    end
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_nios_start_ctrl.sv
// Self-checking bench for nios_start_ctrl: expected read data queued at issue, checked on return.
module tb_nios_start_ctrl;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Hold = 8;
`ifdef NIOS_START_CTRL_HOLD_EN
  localparam logic [31:0] MaskAll = 32'h3;
`else
  localparam logic [31:0] MaskAll = 32'h1;
`endif

  logic clk;
  logic reset_n;
  logic in_port;
  logic irq;

  nios_start_ctrl_if bus ();

  nios_start_ctrl #(
    .DEBOUNCE_CYCLES (Deb),
    .CNT_W           (3),
    .HOLD_CYCLES     (Hold),
    .HOLD_W          (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .in_port (in_port),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One active edge; everything is driven and sampled 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 32'h1, 32'h0);
    end else begin
      exp = exp_q.pop_front();
      check_eq(tag, bus.readdata, exp);
    end
  endtask

  task automatic bus_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    bus.address = addr;
    exp_q.push_back(exp);
    tick();
    pop_check(tag);
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  // Hold in_port high from before edge 1; DATA is registered so edge k shows state after edge k-1:
  // s2 is high after edge 2, level after edge Deb+3.
  task automatic press_sequence(input string tag);
    logic [31:0] exp;
    bus.address = 2'd0;
    for (int k = 1; k <= int'(Deb) + 5; k++) begin
      exp = 32'h0;
      if (k - 1 >= 2) exp[1] = 1'b1;
      if (k - 1 >= int'(Deb) + 3) exp[0] = 1'b1;
      exp_q.push_back(exp);
      tick();
      pop_check($sformatf("%s_data_edge%0d", tag, k));
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    in_port        = 1'b0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // Reset state
    ticks(3);
    check_eq("rst_readdata", bus.readdata, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    tick();
    bus_read("rst_addr0", 2'd0, 32'h0);
    bus_read("rst_addr1", 2'd1, 32'h0);
    bus_read("rst_addr2", 2'd2, 32'h0);
    bus_read("rst_addr3", 2'd3, 32'h0);
    check_eq("rst_irq_after", {31'b0, irq}, 32'h0);

    // Clean press: debounce latency and capture
    in_port = 1'b1;
    press_sequence("press");
    bus_read("press_capture", 2'd3, 32'h1);
    check_eq("press_irq_masked", {31'b0, irq}, 32'h0);
    in_port = 1'b0;
    ticks(10);
    bus_read("release_data", 2'd0, 32'h0);
    bus_read("release_no_capture", 2'd3, 32'h1);

    // Mask and clear behaviour
    bus_write(2'd2, 32'h1);
    check_eq("mask_irq_on", {31'b0, irq}, 32'h1);
    bus_read("mask_read", 2'd2, 32'h1);
    bus_write(2'd3, 32'h0);
    check_eq("clr0_irq_kept", {31'b0, irq}, 32'h1);
    bus_read("clr0_capture_kept", 2'd3, 32'h1);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read("reserved_read", 2'd1, 32'h0);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read("mask_all_ones", 2'd2, MaskAll);
    bus_write(2'd2, 32'h1);
    bus_write(2'd3, 32'h1);
    check_eq("clr1_irq_off", {31'b0, irq}, 32'h0);
    bus_read("clr1_capture", 2'd3, 32'h0);

    // Short glitch is filtered
    in_port = 1'b1;
    ticks(Deb - 1);
    in_port = 1'b0;
    ticks(12);
    bus_read("glitch_data", 2'd0, 32'h0);
    bus_read("glitch_capture", 2'd3, 32'h0);
    check_eq("glitch_irq", {31'b0, irq}, 32'h0);

    // Clear write on the same edge as the press pulse: set wins
    in_port = 1'b1;
    ticks(Deb + 2);
    bus_write(2'd3, 32'h1);
    check_eq("race_irq", {31'b0, irq}, 32'h1);
    bus_read("race_capture", 2'd3, 32'h1);
    bus_read("race_data", 2'd0, 32'h3);
    bus_write(2'd3, 32'h1);
    bus_read("race_cleared", 2'd3, 32'h0);
    in_port = 1'b0;
    ticks(10);
    bus_read("race_release", 2'd0, 32'h0);

    // Reset in the middle of the debounce window
    in_port = 1'b1;
    ticks(4);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_readdata", bus.readdata, 32'h0);
    check_eq("midrst_irq", {31'b0, irq}, 32'h0);
    tick();
    reset_n = 1'b1;
    press_sequence("restart");
    bus_read("restart_mask", 2'd2, 32'h0);
    bus_read("restart_capture", 2'd3, 32'h1);
    check_eq("restart_irq", {31'b0, irq}, 32'h0);

`ifdef NIOS_START_CTRL_HOLD_EN
    // Long press fires once per press
    ticks(20);
    bus_read("hold_set", 2'd3, 32'h3);
    bus_write(2'd3, 32'h2);
    bus_read("hold_cleared", 2'd3, 32'h1);
    ticks(20);
    bus_read("hold_once", 2'd3, 32'h1);
`else
    bus_write(2'd3, 32'h2);
    bus_read("bit1_ignored", 2'd3, 32'h1);
`endif
    in_port = 1'b0;
    ticks(10);
    bus_read("final_data", 2'd0, 32'h0);
    check_eq("queue_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
